// File: rtl/lsu_port_arbiter_pkg.sv
// Shared types for the LSU port arbiter: FSM encoding, access-size width and
// the helper that picks the "other" pipe's pending flag.
package lsu_port_arbiter_pkg;

    localparam int LSARB_SIZE_W = 2;

    typedef enum logic [1:0] {
        LSARB_IDLE  = 2'd0,
        LSARB_REQ   = 2'd1,
        LSARB_RESP  = 2'd2,
        LSARB_DRAIN = 2'd3
    } lsarb_state_e;

    // Pending flag of the pipe that does not currently own the port.
    function automatic logic other_pending(input logic owner,
                                           input logic pend0,
                                           input logic pend1);
        return owner ? pend0 : pend1;
    endfunction

endpackage

// File: rtl/lsu_port_arbiter_req_mux.sv
// Registered request-field selector: captures pipe-0 or pipe-1 access fields
// on a grant so the Dcache sees stable fields for the whole request.
module lsu_req_mux
    import lsu_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_load,
    input  logic                    i_sel,
    input  logic                    i_we0,
    input  logic [LSARB_SIZE_W-1:0] i_size0,
    input  logic [ADDR_WIDTH-1:0]   i_addr0,
    input  logic [DATA_WIDTH-1:0]   i_wdata0,
    input  logic                    i_we1,
    input  logic [LSARB_SIZE_W-1:0] i_size1,
    input  logic [ADDR_WIDTH-1:0]   i_addr1,
    input  logic [DATA_WIDTH-1:0]   i_wdata1,
    output logic                    o_we,
    output logic [LSARB_SIZE_W-1:0] o_size,
    output logic [ADDR_WIDTH-1:0]   o_addr,
    output logic [DATA_WIDTH-1:0]   o_wdata
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_we    <= 1'b0;
            o_size  <= '0;
            o_addr  <= '0;
            o_wdata <= '0;
        end else if (i_load) begin
            o_we    <= i_sel ? i_we1    : i_we0;
            o_size  <= i_sel ? i_size1  : i_size0;
            o_addr  <= i_sel ? i_addr1  : i_addr0;
            o_wdata <= i_sel ? i_wdata1 : i_wdata0;
        end
    end

endmodule

// File: rtl/lsu_port_arbiter.sv
// Shares the single Dcache request port between the two issue pipes, oldest
// (pipe 0) first, one outstanding request at a time, and drives the stall.
module lsu_port_arbiter
    import lsu_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req0_valid,
    input  logic                    req0_we,
    input  logic [LSARB_SIZE_W-1:0] req0_size,
    input  logic [ADDR_WIDTH-1:0]   req0_addr,
    input  logic [DATA_WIDTH-1:0]   req0_wdata,
    input  logic                    req1_valid,
    input  logic                    req1_we,
    input  logic [LSARB_SIZE_W-1:0] req1_size,
    input  logic [ADDR_WIDTH-1:0]   req1_addr,
    input  logic [DATA_WIDTH-1:0]   req1_wdata,
    input  logic                    flush,
    output logic                    dc_req_valid,
    input  logic                    dc_req_ready,
    output logic                    dc_we,
    output logic [LSARB_SIZE_W-1:0] dc_size,
    output logic [ADDR_WIDTH-1:0]   dc_addr,
    output logic [DATA_WIDTH-1:0]   dc_wdata,
    input  logic                    dc_rsp_valid,
    input  logic [DATA_WIDTH-1:0]   dc_rsp_rdata,
    output logic                    rsp0_valid,
    output logic                    rsp1_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    stall_req,
    output logic                    fence_done
);

    lsarb_state_e r_state;
    lsarb_state_e w_state_nxt;
    logic         r_owner;
    logic         r_done0;
    logic         r_done1;
    logic         w_owner_nxt;
    logic         w_pend0;
    logic         w_pend1;
    logic         w_load;
    logic         w_sel;
    logic         w_set_done0;
    logic         w_set_done1;
    logic         w_last_rsp;

    assign w_pend0 = req0_valid & ~r_done0;
    assign w_pend1 = req1_valid & ~r_done1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= LSARB_IDLE;
            r_owner <= 1'b0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            // Completion flags only live while the bundle is held.
            r_done0 <= stall_req & (r_done0 | w_set_done0);
            r_done1 <= stall_req & (r_done1 | w_set_done1);
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_owner_nxt  = r_owner;
        w_load       = 1'b0;
        w_sel        = 1'b0;
        w_set_done0  = 1'b0;
        w_set_done1  = 1'b0;
        w_last_rsp   = 1'b0;
        rsp0_valid   = 1'b0;
        rsp1_valid   = 1'b0;
        dc_req_valid = 1'b0;
        case (r_state)
            LSARB_IDLE: begin
                if (!flush) begin
                    if (w_pend0) begin
                        w_load      = 1'b1;
                        w_sel       = 1'b0;
                        w_owner_nxt = 1'b0;
                        w_state_nxt = LSARB_REQ;
                    end else if (w_pend1) begin
                        w_load      = 1'b1;
                        w_sel       = 1'b1;
                        w_owner_nxt = 1'b1;
                        w_state_nxt = LSARB_REQ;
                    end
                end
            end
            LSARB_REQ: begin
                // Withdraw the request outright so a same-cycle ready cannot accept it.
                dc_req_valid = ~flush;
                if (flush)
                    w_state_nxt = LSARB_IDLE;
                else if (dc_req_ready)
                    w_state_nxt = LSARB_RESP;
            end
            LSARB_RESP: begin
                if (flush) begin
                    w_state_nxt = dc_rsp_valid ? LSARB_IDLE : LSARB_DRAIN;
                end else if (dc_rsp_valid) begin
                    rsp0_valid  = ~r_owner;
                    rsp1_valid  = r_owner;
                    w_set_done0 = ~r_owner;
                    w_set_done1 = r_owner;
                    if (other_pending(r_owner, w_pend0, w_pend1)) begin
                        w_load      = 1'b1;
                        w_sel       = ~r_owner;
                        w_owner_nxt = ~r_owner;
                        w_state_nxt = LSARB_REQ;
                    end else begin
                        w_last_rsp  = 1'b1;
                        w_state_nxt = LSARB_IDLE;
                    end
                end
            end
            LSARB_DRAIN: begin
                if (dc_rsp_valid)
                    w_state_nxt = LSARB_IDLE;
            end
            default: w_state_nxt = LSARB_IDLE;
        endcase
    end

    assign stall_req  = (w_pend0 | w_pend1) & ~w_last_rsp & ~flush;
    assign fence_done = (r_state == LSARB_IDLE) & ~w_pend0 & ~w_pend1;
    assign rsp_rdata  = dc_rsp_rdata;

    lsu_req_mux #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_req_mux (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_load),
        .i_sel    (w_sel),
        .i_we0    (req0_we),
        .i_size0  (req0_size),
        .i_addr0  (req0_addr),
        .i_wdata0 (req0_wdata),
        .i_we1    (req1_we),
        .i_size1  (req1_size),
        .i_addr1  (req1_addr),
        .i_wdata1 (req1_wdata),
        .o_we     (dc_we),
        .o_size   (dc_size),
        .o_addr   (dc_addr),
        .o_wdata  (dc_wdata)
    );

endmodule
